// File: rtl/interface_entrada.sv
// ---------------------------------------------------------------------------
// interface_entrada
//
// Input front-end for the game core. Raw board inputs (12 note buttons plus
// right / left / enter navigation keys) are synchronised, debounced per line,
// and turned into the bundle the main circuit consumes: a priority-encoded
// note code with a "new note" strobe, and single-cycle key pulses. The arrow
// keys auto-repeat while held so menus can be scrolled.
//
// Ports
//   clock               in   system clock, all state on its rising edge
//   reset               in   synchronous, active-high
//   botoes[11:0]        in   raw note buttons, active-high, asynchronous
//   right_arrow         in   raw right key, active-high, asynchronous
//   left_arrow          in   raw left key, active-high, asynchronous
//   enter               in   raw enter key, active-high, asynchronous
//   botoes_encoded[3:0] out  0 = no note, 1..12 = lowest pressed index + 1
//   nova_nota           out  1-cycle pulse when the code takes a new nonzero value
//   right_arrow_pressed out  1-cycle press / auto-repeat pulse
//   left_arrow_pressed  out  1-cycle press / auto-repeat pulse
//   enter_pressed       out  1-cycle press pulse, no repeat
// ---------------------------------------------------------------------------
module interface_entrada #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 7500000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] botoes,
   input  logic        right_arrow,
   input  logic        left_arrow,
   input  logic        enter,
   output logic [3:0]  botoes_encoded,
   output logic        nova_nota,
   output logic        right_arrow_pressed,
   output logic        left_arrow_pressed,
   output logic        enter_pressed
);

   localparam int N_LINES   = 15;
   localparam int IDX_RIGHT = 12;
   localparam int IDX_ENTER = 14;

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX);
   localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      OCIOSO,
      ESPERA,
      REPETE
   } arrow_state_t;

   // Lowest pressed index wins; 0 means nothing pressed.
   function automatic logic [3:0] lowest_note(input logic [11:0] v);
      logic [3:0] code;
      code = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (v[i]) code = 4'(i + 1);
      end
      return code;
   endfunction

   logic [N_LINES-1:0] raw_lines;
   logic [N_LINES-1:0] sync_p0;
   logic [N_LINES-1:0] sync_p1;
   logic [N_LINES-1:0] deb_p2;
   logic [N_LINES-1:0] deb_p3;
   logic [DB_W-1:0]    db_cnt [N_LINES];
   logic [3:0]         code_nxt;

   assign raw_lines = {enter, left_arrow, right_arrow, botoes};

   // ---- stage p0/p1: two-flop synchroniser on every raw line ----
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw_lines;
         sync_p1 <= sync_p0;
      end
   end

   // ---- stage p2: independent debouncer per line ----
   // The counter only runs while the synchronised level disagrees with the
   // debounced one, so any disagreement shorter than DEBOUNCE_CYCLES is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_p2 <= '0;
         for (int i = 0; i < N_LINES; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_LINES; i++) begin
            if (sync_p1[i] == deb_p2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb_p2[i] <= ~deb_p2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign code_nxt = lowest_note(deb_p2[11:0]);

   // ---- stage p3: encoder, new-note strobe, enter edge ----
   // deb_p3 is the previous debounced vector, used for rising-edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         botoes_encoded <= 4'd0;
         nova_nota      <= 1'b0;
         enter_pressed  <= 1'b0;
         deb_p3         <= '0;
      end else begin
         botoes_encoded <= code_nxt;
         nova_nota      <= (code_nxt != 4'd0) && (code_nxt != botoes_encoded);
         enter_pressed  <= deb_p2[IDX_ENTER] & ~deb_p3[IDX_ENTER];
         deb_p3         <= deb_p2;
      end
   end

   // ---- stage p3: arrow auto-repeat FSMs (index 0 = right, 1 = left) ----
   for (genvar a = 0; a < 2; a++) begin : g_arrow
      arrow_state_t    state;
      logic [RP_W-1:0] cnt;
      logic            pulse;
      logic            held;
      logic            rise;

      assign held = deb_p2[IDX_RIGHT + a];
      assign rise = held & ~deb_p3[IDX_RIGHT + a];

      always_ff @(posedge clock) begin
         if (reset) begin
            state <= OCIOSO;
            cnt   <= '0;
            pulse <= 1'b0;
         end else begin
            pulse <= 1'b0;
            if (!held) begin
               // A release aborts any pending repeat, silently.
               state <= OCIOSO;
               cnt   <= '0;
            end else begin
               case (state)
                  OCIOSO: begin
                     if (rise) begin
                        pulse <= 1'b1;
                        cnt   <= '0;
                        state <= ESPERA;
                     end
                  end
                  ESPERA: begin
                     if (cnt == DELAY_LAST) begin
                        pulse <= 1'b1;
                        cnt   <= '0;
                        state <= REPETE;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  REPETE: begin
                     if (cnt == PERIOD_LAST) begin
                        pulse <= 1'b1;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  default: begin
                     state <= OCIOSO;
                     cnt   <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign right_arrow_pressed = g_arrow[0].pulse;
   assign left_arrow_pressed  = g_arrow[1].pulse;

endmodule

// File: tb/tb_interface_entrada.sv
// ---------------------------------------------------------------------------
// tb_interface_entrada
//
// Bench for interface_entrada with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Directed scenarios check exact timings; a random phase
// compares every cycle against a behavioural model that reasons in terms of
// input run lengths and key hold times.
// ---------------------------------------------------------------------------
module tb_interface_entrada;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic        clock;
   logic        reset;
   logic [11:0] botoes;
   logic        right_arrow;
   logic        left_arrow;
   logic        enter;
   logic [3:0]  botoes_encoded;
   logic        nova_nota;
   logic        right_arrow_pressed;
   logic        left_arrow_pressed;
   logic        enter_pressed;

   int total = 0;
   int bad   = 0;

   interface_entrada #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .botoes             (botoes),
      .right_arrow        (right_arrow),
      .left_arrow         (left_arrow),
      .enter              (enter),
      .botoes_encoded     (botoes_encoded),
      .nova_nota          (nova_nota),
      .right_arrow_pressed(right_arrow_pressed),
      .left_arrow_pressed (left_arrow_pressed),
      .enter_pressed      (enter_pressed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural reference model ----------------
   logic [14:0] m_pipe [$];      // raw samples still in flight to the debouncer
   int          m_run  [15];     // length of current run of identical samples
   logic [14:0] m_last;          // value of that run
   logic [14:0] m_deb;           // debounced levels
   logic [14:0] m_deb_old;       // debounced levels one cycle earlier
   int          m_hold [2];      // cycles since arrow press, -1 when released
   logic [3:0]  exp_code;
   logic        exp_nova;
   logic        exp_right;
   logic        exp_left;
   logic        exp_enter;

   function automatic logic [3:0] lowest_set(input logic [11:0] v);
      for (int i = 0; i < 12; i++) if (v[i]) return 4'(i + 1);
      return 4'd0;
   endfunction

   function automatic logic repeat_due(input int h);
      return (h == 0) || (h == RD) || (h > RD && ((h - RD) % RP) == 0);
   endfunction

   task automatic model_step(input logic rst_i, input logic [14:0] raw_i);
      logic [14:0] sample;
      logic [14:0] rise;
      logic [3:0]  code;
      logic        p [2];
      if (rst_i) begin
         m_pipe = {};
         m_pipe.push_back(15'd0);
         m_pipe.push_back(15'd0);
         for (int i = 0; i < 15; i++) m_run[i] = 0;
         m_last = '0; m_deb = '0; m_deb_old = '0;
         m_hold[0] = -1; m_hold[1] = -1;
         exp_code = 0; exp_nova = 0; exp_right = 0; exp_left = 0; exp_enter = 0;
         return;
      end
      code      = lowest_set(m_deb[11:0]);
      exp_nova  = (code != 0) && (code != exp_code);
      exp_code  = code;
      rise      = m_deb & ~m_deb_old;
      exp_enter = rise[14];
      for (int a = 0; a < 2; a++) begin
         if (rise[12+a]) m_hold[a] = 0;
         else if (m_deb[12+a] && m_hold[a] >= 0) m_hold[a]++;
         else m_hold[a] = -1;
         p[a] = (m_hold[a] >= 0) && repeat_due(m_hold[a]);
      end
      exp_right = p[0];
      exp_left  = p[1];
      m_deb_old = m_deb;
      sample = m_pipe.pop_front();
      m_pipe.push_back(raw_i);
      for (int i = 0; i < 15; i++) begin
         if (sample[i] == m_last[i]) m_run[i]++;
         else begin m_run[i] = 1; m_last[i] = sample[i]; end
         if (sample[i] != m_deb[i] && m_run[i] >= D) m_deb[i] = sample[i];
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      model_step(reset, {enter, left_arrow, right_arrow, botoes});
      #1;
   endtask

   function automatic logic [7:0] obs();
      return {botoes_encoded, nova_nota, right_arrow_pressed, left_arrow_pressed, enter_pressed};
   endfunction

   task automatic clear_and_settle();
      botoes = '0; right_arrow = 0; left_arrow = 0; enter = 0; reset = 0;
      repeat (20) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      botoes = 12'hFFF; right_arrow = 1; left_arrow = 1; enter = 1; reset = 1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         total++;
         if (obs() !== 8'h00) begin
            bad++; $display("FAIL reset_hold cyc%0d: got %h want 00", n, obs());
         end
      end
      reset = 0;
      for (int n = 1; n <= 9; n++) begin
         logic [7:0] want;
         tick();
         want = (n < 7) ? 8'h00 : (n == 7) ? 8'h1F : 8'h10;
         total++;
         if (obs() !== want) begin
            bad++; $display("FAIL reset_release n=%0d: got %h want %h", n, obs(), want);
         end
      end
      clear_and_settle();
   endtask

   task automatic test_press();
      botoes[4] = 1;
      for (int n = 1; n <= 12; n++) begin
         logic [4:0] want;
         tick();
         want = {((n >= 7) ? 4'd5 : 4'd0), (n == 7)};
         total++;
         if ({botoes_encoded, nova_nota} !== want) begin
            bad++; $display("FAIL press n=%0d: got %h want %h", n, {botoes_encoded, nova_nota}, want);
         end
      end
      botoes[4] = 0;
      for (int n = 1; n <= 12; n++) begin
         logic [4:0] want;
         tick();
         want = {((n >= 7) ? 4'd0 : 4'd5), 1'b0};
         total++;
         if ({botoes_encoded, nova_nota} !== want) begin
            bad++; $display("FAIL release n=%0d: got %h want %h", n, {botoes_encoded, nova_nota}, want);
         end
      end
      clear_and_settle();
   endtask

   task automatic test_glitch();
      botoes[7] = 1; enter = 1;
      for (int n = 1; n <= 23; n++) begin
         if (n == 4) begin botoes[7] = 0; enter = 0; end
         tick();
         total++;
         if (obs() !== 8'h00) begin
            bad++; $display("FAIL glitch n=%0d: got %h want 00", n, obs());
         end
      end
      clear_and_settle();
   endtask

   task automatic test_priority();
      logic [3:0] before_c [4];
      logic [3:0] after_c  [4];
      logic       pulse    [4];
      before_c = '{4'd0, 4'd10, 4'd3, 4'd10};
      after_c  = '{4'd10, 4'd3, 4'd10, 4'd0};
      pulse    = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: botoes[9] = 1;
            1: botoes[2] = 1;
            2: botoes[2] = 0;
            default: botoes[9] = 0;
         endcase
         for (int n = 1; n <= 12; n++) begin
            logic [4:0] want;
            tick();
            want = {((n >= 7) ? after_c[ph] : before_c[ph]), (n == 7) && pulse[ph]};
            total++;
            if ({botoes_encoded, nova_nota} !== want) begin
               bad++; $display("FAIL priority ph%0d n=%0d: got %h want %h", ph, n, {botoes_encoded, nova_nota}, want);
            end
         end
      end
      clear_and_settle();
   endtask

   task automatic test_repeat();
      left_arrow = 1;
      for (int n = 1; n <= 66; n++) begin
         logic want;
         tick();
         want = (n >= 7) && repeat_due(n - 7);
         total++;
         if ({right_arrow_pressed, left_arrow_pressed} !== {1'b0, want}) begin
            bad++; $display("FAIL repeat r=%0d: got r%b l%b want l%b", n - 7, right_arrow_pressed, left_arrow_pressed, want);
         end
      end
      left_arrow = 0;
      for (int k = 1; k <= 30; k++) begin
         logic want;
         tick();
         want = (k <= 6) && repeat_due(59 + k);
         total++;
         if (left_arrow_pressed !== want) begin
            bad++; $display("FAIL repeat_release k=%0d: got %b want %b", k, left_arrow_pressed, want);
         end
      end
      clear_and_settle();
   endtask

   task automatic test_enter_hold();
      enter = 1;
      for (int n = 1; n <= 67; n++) begin
         tick();
         total++;
         if (enter_pressed !== (n == 7)) begin
            bad++; $display("FAIL enter_hold n=%0d: got %b want %b", n, enter_pressed, (n == 7));
         end
      end
      clear_and_settle();
   endtask

   task automatic test_reset_mid_repeat();
      right_arrow = 1;
      for (int n = 1; n <= 32; n++) begin
         tick();
         total++;
         if (right_arrow_pressed !== (n == 7 || n == 27)) begin
            bad++; $display("FAIL mid_pre n=%0d: got %b want %b", n, right_arrow_pressed, (n == 7 || n == 27));
         end
      end
      reset = 1;
      tick();
      total++;
      if (obs() !== 8'h00) begin
         bad++; $display("FAIL mid_reset: got %h want 00", obs());
      end
      reset = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         total++;
         if (right_arrow_pressed !== (k == 7 || k == 27)) begin
            bad++; $display("FAIL mid_post k=%0d: got %b want %b", k, right_arrow_pressed, (k == 7 || k == 27));
         end
      end
      clear_and_settle();
   endtask

   task automatic test_random();
      logic [14:0] cur;
      cur = '0;
      for (int s = 0; s < 150; s++) begin
         int dur;
         cur[$urandom_range(0, 14)] ^= 1'b1;
         if ($urandom_range(0, 1) == 1) cur[$urandom_range(0, 14)] ^= 1'b1;
         {enter, left_arrow, right_arrow, botoes} = cur;
         reset = ($urandom_range(0, 24) == 0);
         dur = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
         for (int c = 0; c < dur; c++) begin
            logic [7:0] want;
            tick();
            reset = 0;
            want = {exp_code, exp_nova, exp_right, exp_left, exp_enter};
            total++;
            if (obs() !== want) begin
               bad++; $display("FAIL random seg%0d c%0d: got %h want %h", s, c, obs(), want);
            end
         end
      end
      clear_and_settle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; botoes = '0; right_arrow = 0; left_arrow = 0; enter = 0;
      test_reset();
      test_press();
      test_glitch();
      test_priority();
      test_repeat();
      test_enter_hold();
      test_reset_mid_repeat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interface_entrada.md
Name: interface_entrada

Overview:
- Input front-end that produces the player-input bundle consumed by the main game circuit.
- Turns 12 raw note buttons and 3 raw navigation keys (right, left, enter) into the signals the core expects:
  - a 4-bit encoded note `botoes_encoded`;
  - single-cycle `right_arrow_pressed`, `left_arrow_pressed` and `enter_pressed` pulses.
- Performs synchronisation, per-line debouncing, priority encoding, edge detection, and auto-repeat on the arrow keys for menu navigation.
- Sits between the board pins and the main circuit.

Parameters:
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable cycles before a line's debounced value changes (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 25000000: cycles an arrow must stay held before auto-repeat starts; must be ≥ 2.
- `REPEAT_PERIOD`, 7500000: cycles between auto-repeat pulses; must be ≥ 2.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `botoes`  in  12  raw note buttons, active-high, asynchronous to `clock`
- `right_arrow`  in  1  raw right key, active-high, async
- `left_arrow`  in  1  raw left key, active-high, async
- `enter`  in  1  raw enter key, active-high, async
- `botoes_encoded`  out  4  0 = no note; 1..12 = note index + 1
- `nova_nota`  out  1  one-cycle pulse when `botoes_encoded` changes to a nonzero value
- `right_arrow_pressed`  out  1  one-cycle press/repeat pulse
- `left_arrow_pressed`  out  1  one-cycle press/repeat pulse
- `enter_pressed`  out  1  one-cycle press pulse, no repeat

Behaviour:
- **Interface decision:** one clock, `clock`. `reset` is synchronous and active-high. All state updates happen on the rising edge of `clock`.
- **Reset values:** all outputs 0, synchronisers 0, debounced values 0, counters 0, repeat FSMs in OCIOSO. A reset asserted mid-operation behaves identically. A button still held after reset re-registers as a fresh press once it has been stable for `DEBOUNCE_CYCLES` cycles.
- **Synchroniser:** every raw line (15 total) passes through a 2-flop synchroniser.
- **Debouncer (one per line, independent):**
  - Counter width is `clog2(DEBOUNCE_CYCLES)`.
  - If the synchronised value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` while still differing, the debounced value toggles and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **Latency:** exactly `DEBOUNCE_CYCLES+3` rising edges from the first edge that samples the new raw level to the corresponding registered output change.
- **Encoder:**
  - `botoes_encoded` is registered. It equals the lowest set index of the debounced 12-bit vector plus 1, or 0 if no bit is set.
  - Multiple simultaneous buttons: the lowest index wins.
  - `nova_nota` pulses for 1 cycle in the same cycle that `botoes_encoded` takes a new nonzero value. This includes a direct change from one nonzero code to another. It does not pulse on a change to 0.
- **Enter:** `enter_pressed` pulses for 1 cycle on the debounced rising edge only. Holding the key gives no further pulses.
- **Arrow FSM (one per arrow, independent; both may pulse in the same cycle):**
  - OCIOSO: on debounced rise, emit a pulse, clear the counter, go to ESPERA.
  - ESPERA: the counter increments each cycle. At `REPEAT_DELAY-1`, emit a pulse, clear the counter, go to REPETE.
  - REPETE: the counter increments. At `REPEAT_PERIOD-1`, emit a pulse and clear the counter.
  - From any state, a debounced fall returns to OCIOSO with the counter cleared and no pulse.
  - A repeat counter has no wrap-around hazard: it is sized `clog2(max(REPEAT_DELAY, REPEAT_PERIOD))` and always cleared at its terminal value.
- **Pulse width:** all pulses are exactly one clock wide and registered. No output is combinational from an input.

Test Plan (`DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`):
- **Reset:** assert `reset` 3 cycles with all inputs high → all outputs 0 during reset. After release, `botoes_encoded=1` and a single `nova_nota` pulse arrive 7 edges later, together with `right_arrow_pressed`, `left_arrow_pressed` and `enter_pressed` pulses.
- **Debounced press:** hold `botoes[4]` high → `botoes_encoded=5` exactly 7 edges after first sample, `nova_nota` high for exactly 1 cycle. Release → returns to 0 after 7 edges, no `nova_nota`.
- **Glitch rejection:** pulse `botoes[7]` or `enter` high for 3 cycles → no output change ever.
- **Priority:** `botoes[9]` stable, then `botoes[2]` added → code goes 10 → 3 with a second `nova_nota` pulse. Release `botoes[2]` → code 10, third `nova_nota` pulse.
- **Auto-repeat:** hold `left_arrow` for 60 cycles after debounce → pulses at relative cycles 0, 20, 28, 36, 44, 52 (6 total). Release → no further pulses. `enter` held 60 cycles → exactly 1 pulse.
- **Reset mid-repeat:** while `right_arrow` is in REPETE, assert `reset` 1 cycle with the key still held → no pulse for 6 edges after reset release, then a fresh pulse, then the next pulse 20 cycles later.
